dest_fifo: RTL

//  Per-destination buffer directly downstream of the destination demux: one

---
 rtl/dest_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/dest_fifo.sv
// dest_fifo: per-destination circular buffer placed after the destination demux.
// It has a registered pop port, full/empty and almost-full/almost-empty flags,
// and a sticky overflow/underflow error flag.
// Optional build macro DEST_FIFO_COUNT_EN adds the fifo_count output port.
module dest_fifo #(
  parameter int DATA_SIZE    = 6,
  parameter int ADDR_SIZE    = 2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
`ifdef DEST_FIFO_COUNT_EN
  ,
  output logic [ADDR_SIZE:0]   fifo_count
`endif
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_COUNT   = (ADDR_SIZE + 1)'(ALMOST_FULL);
  localparam logic [ADDR_SIZE:0] AE_COUNT   = (ADDR_SIZE + 1)'(ALMOST_EMPTY);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   count;
  logic                 wr_en;
  logic                 rd_en;

  // Flags decode the registered count directly, so they add no latency.
  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_COUNT);
  assign almost_empty = (count <= AE_COUNT);

  // Full and empty are judged on the current count, so a pop in the same
  // cycle cannot rescue a push into a full buffer.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

`ifdef DEST_FIFO_COUNT_EN
  assign fifo_count = count;
`endif

  // Storage array: accepted writes only.
  // NOTE: the array is deliberately left out of reset. Reset clears the pointers
  // and count, so any stale contents can never be read back, and this keeps the
  // array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, registered read port and sticky error.
  // NOTE: every register here uses non-blocking assignment. data_out therefore
  // samples the pre-edge rd_ptr, even though rd_ptr advances on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out <= rd_en;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((push && full) || (pop && empty)) begin
        error <= 1'b1;
      end
    end
  end

endmodule
